// File: rtl/ifu_fetch.sv
// Instruction fetch stage: issues word fetches over req/gnt/rvalid, keeps an in-order
// response queue, hands instructions to IF/ID and redirects on jump, discarding stale responses.
module ifu_fetch #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned          FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   jump_i,
    input  logic [PC_WIDTH-1:0]    jump_addr_i,
    output logic                   imem_req_o,
    output logic [PC_WIDTH-1:0]    imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic                   if_valid_o,
    output logic                   dbg_state_o
);

    // Handshake: a request transfers in any cycle with imem_req_o & imem_gnt_i; responses
    // arrive in request order as imem_rvalid_i pulses; IF/ID takes the head whenever
    // if_valid_o & ~stall_i & ~jump_i.

    localparam int unsigned        PW       = $clog2(FIFO_DEPTH);
    localparam int unsigned        CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]      PTR_ONE  = PW'(1);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] NOP  = INSTR_WIDTH'(32'h0000_0013);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [PC_WIDTH-1:0]    fetch_pc;
    logic [PC_WIDTH-1:0]    pc_q    [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  has_data_q;

    logic [PW-1:0] head_ptr, alloc_ptr, fill_ptr;
    logic [CW-1:0] alloc_cnt, pending, discard_cnt, discard_nxt;
    logic [CW-1:0] redirect_base, redirect_cnt;

    logic head_valid, pop, gnt_acc, fill;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^jump_addr_i[1:0];

    assign head_valid = has_data_q[head_ptr];
    assign pop        = head_valid & ~stall_i & ~jump_i;
    assign imem_req_o = ~rst & (state == FETCH) & ~jump_i & (alloc_cnt < CNT_FULL);
    assign imem_addr_o = fetch_pc;
    assign gnt_acc    = imem_req_o & imem_gnt_i;
    // A response with nothing pending in FETCH is a protocol error and is ignored.
    assign fill       = imem_rvalid_i & (state == FETCH) & (pending != '0);

    assign if_valid_o  = head_valid;
    assign if_pc_o     = head_valid ? pc_q[head_ptr] : '0;
    assign if_instr_o  = head_valid ? instr_q[head_ptr] : NOP;
    assign dbg_state_o = (state == DRAIN);

    // Responses still owed by memory after a redirect, minus one arriving right now.
    assign redirect_base = (state == FETCH) ? pending : discard_cnt;
    assign redirect_cnt  = (imem_rvalid_i && redirect_base != '0) ? redirect_base - CNT_ONE
                                                                  : redirect_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard_cnt;
        if (jump_i) begin
            discard_nxt = redirect_cnt;
            state_nxt   = (redirect_cnt != '0) ? DRAIN : FETCH;
        end else if (state == DRAIN && imem_rvalid_i) begin
            discard_nxt = discard_cnt - CNT_ONE;
            if (discard_cnt == CNT_ONE) begin
                state_nxt = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            head_ptr   <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            alloc_cnt  <= '0;
            pending    <= '0;
            has_data_q <= '0;
        end else if (jump_i) begin
            fetch_pc   <= {jump_addr_i[PC_WIDTH-1:2], 2'b00};
            head_ptr   <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            alloc_cnt  <= '0;
            pending    <= '0;
            has_data_q <= '0;
        end else begin
            if (gnt_acc) begin
                pc_q[alloc_ptr]       <= fetch_pc;
                has_data_q[alloc_ptr] <= 1'b0;
                alloc_ptr             <= alloc_ptr + PTR_ONE;
                fetch_pc              <= fetch_pc + PC_STEP;
            end
            if (fill) begin
                instr_q[fill_ptr]    <= imem_rdata_i;
                has_data_q[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + PTR_ONE;
            end
            if (pop) begin
                has_data_q[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + PTR_ONE;
            end
            alloc_cnt <= alloc_cnt + (gnt_acc ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            pending   <= pending + (gnt_acc ? CNT_ONE : '0) - (fill ? CNT_ONE : '0);
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: an in-order memory responder drives the fetch port and a
// negedge monitor compares every output against a queue-based model of fetch/redirect behaviour.
module tb_ifu_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;
    logic        dbg_state_o;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .if_pc_o      (if_pc_o),
        .if_instr_o   (if_instr_o),
        .if_valid_o   (if_valid_o),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } resp_t;

    resp_t       mem_q[$];
    logic [31:0] exp_q[$];
    int tests = 0, fails = 0, cyc = 0, handovers = 0;
    int gnt_pct = 100, rv_pct = 100, dmax = 0;
    int m_alloc = 0, m_filled = 0, m_stale = 0;
    logic [31:0] m_next = '0;
    bit rst_prev = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // expected hand-over order after a restart at target: target, target+4, ...
    task automatic restart(input logic [31:0] target);
        exp_q.delete();
        for (int k = 0; k < 64; k++) exp_q.push_back(target + 32'(4 * k));
    endtask

    // driver tasks
    task automatic tick(input bit s, input bit j, input logic [31:0] ja);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        stall_i = s;
        jump_i = j;
        jump_addr_i = ja;
        imem_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(1, 100) <= rv_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = word_of(mem_q[0].addr);
            mem_q.delete(0);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            rst = 1'b1;
            stall_i = 1'b0;
            jump_i = 1'b0;
            imem_gnt_i = 1'b0;
            imem_rvalid_i = 1'b0;
            mem_q.delete();
        end
    endtask

    task automatic run(input int n, input int stall_pct, input int jump_pct);
        for (int k = 0; k < n; k++)
            tick($urandom_range(1, 100) <= stall_pct, $urandom_range(1, 100) <= jump_pct, $urandom);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        bit          exp_req;
        if (rst) begin
            chk("rst_req", {31'b0, imem_req_o}, 32'd0);
            if (rst_prev) begin
                chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
                chk("rst_pc", if_pc_o, 32'd0);
                chk("rst_instr", if_instr_o, NOP);
            end
            m_alloc = 0;
            m_filled = 0;
            m_stale = 0;
            m_next = '0;
            restart('0);
            rst_prev = 1'b1;
        end else begin
            rst_prev = 1'b0;
            exp_req = !jump_i && m_stale == 0 && m_alloc < DEPTH;
            chk("dbg_state", {31'b0, dbg_state_o}, {31'b0, m_stale > 0});
            chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_filled > 0});
            if (m_filled > 0) begin
                exp_pc = (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF;
                chk("if_pc", if_pc_o, exp_pc);
                chk("if_instr", if_instr_o, word_of(exp_pc));
                if (!stall_i && !jump_i) begin
                    if (exp_q.size() > 0) exp_q.delete(0);
                    m_filled--;
                    m_alloc--;
                    handovers++;
                end
            end else begin
                chk("idle_pc", if_pc_o, 32'd0);
                chk("idle_instr", if_instr_o, NOP);
            end
            chk("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
            if (imem_req_o) chk("imem_addr", imem_addr_o, m_next);
            if (imem_req_o && imem_gnt_i) begin
                mem_q.push_back('{m_next, cyc + 1 + int'($urandom_range(0, dmax))});
                m_alloc++;
                m_next += 32'd4;
            end
            if (imem_rvalid_i) begin
                if (m_stale > 0) m_stale--;
                else m_filled++;
            end
            if (jump_i) begin
                m_filled = 0;
                m_alloc = 0;
                m_stale = mem_q.size();
                m_next = {jump_addr_i[31:2], 2'b00};
                restart(m_next);
            end
        end
    end

    initial begin
        // back-to-back fetch from reset, then a held stall
        do_reset(2);
        gnt_pct = 100; rv_pct = 100; dmax = 0;
        run(12, 0, 0);
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, '0);
        run(10, 0, 0);

        // redirect with two responses outstanding
        do_reset(2);
        rv_pct = 0;
        run(3, 0, 0);
        tick(1'b0, 1'b1, 32'h0000_0103);
        rv_pct = 100;
        run(12, 0, 0);

        // redirect in the same cycle as the last outstanding response
        do_reset(2);
        rv_pct = 0;
        run(3, 0, 0);
        gnt_pct = 0; rv_pct = 100;
        for (int k = 0; k < 10 && mem_q.size() > 1; k++) tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 32'h0000_0200);
        gnt_pct = 100;
        run(8, 0, 0);

        // grant withheld, then reset with data buffered and requests outstanding
        do_reset(2);
        gnt_pct = 0;
        run(3, 0, 0);
        gnt_pct = 100; rv_pct = 100; dmax = 2;
        run(3, 100, 0);
        do_reset(2);
        dmax = 0;
        run(6, 0, 0);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            gnt_pct = int'($urandom_range(30, 100));
            rv_pct = int'($urandom_range(30, 100));
            dmax = int'($urandom_range(0, 3));
            run(90, int'($urandom_range(0, 40)), 6);
            do_reset(int'($urandom_range(1, 2)));
        end
        run(2, 0, 0);

        chk("handovers_seen", {31'b0, handovers > 100}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
